// File: rtl/ghash_sequential_controller.sv
// ghash_sequential_controller
//
// Sequences the GHASH chain Y_i = (Y_{i-1} ^ X_i) * H over GF(2^128) around an
// external bit-serial GF(2^128) multiplier.
// For each accepted block the controller:
//   - presents X = Y ^ block and Y = H to the multiplier;
//   - fires a single-cycle trigger;
//   - waits for the product.
// After the block flagged as last, the product is returned as the hash. The
// chaining value then clears itself so that the next block starts a new hash.
//
// Ports
//   i_clock        clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_hash_key     H, captured when a block is accepted
//   i_block        data block X_i ([127:120] is the first byte)
//   i_block_valid  block present; held until accepted
//   i_block_last   final block of the current hash
//   i_clear        restart hash (Y and block count to 0); only honoured in IDLE
//   o_block_ready  a block can be accepted this cycle
//   o_ghash        last final hash, held until the next final result
//   o_ghash_valid  one-cycle pulse when o_ghash is updated
//   o_block_count  blocks completed since clear/reset, wraps silently
//   o_mul_x        multiplier operand X (Y ^ block)
//   o_mul_y        multiplier operand Y (H)
//   o_mul_valid    multiplier enable, low only during reset
//   o_mul_trigger  multiplier start, one-cycle pulse
//   i_mul_z        multiplier product
//   i_mul_done     multiplier product-ready pulse
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a block; i_clear honoured here
// TRIG  | operands registered, trigger pulse on the multiplier input
// WAIT  | multiplier running; inputs ignored until i_mul_done

module ghash_sequential_controller #(
    parameter int NB_DATA  = 128,
    parameter int NB_COUNT = 32
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [NB_DATA-1:0]  i_hash_key,
    input  logic [NB_DATA-1:0]  i_block,
    input  logic                i_block_valid,
    input  logic                i_block_last,
    input  logic                i_clear,
    output logic                o_block_ready,
    output logic [NB_DATA-1:0]  o_ghash,
    output logic                o_ghash_valid,
    output logic [NB_COUNT-1:0] o_block_count,
    output logic [NB_DATA-1:0]  o_mul_x,
    output logic [NB_DATA-1:0]  o_mul_y,
    output logic                o_mul_valid,
    output logic                o_mul_trigger,
    input  logic [NB_DATA-1:0]  i_mul_z,
    input  logic                i_mul_done
);

    generate
        if (NB_DATA != 128) begin : g_bad_width
            $error("ghash_sequential_controller: NB_DATA must be 128");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [NB_DATA-1:0]  r_y;
    logic                r_last;
    logic                r_block_ready;
    logic [NB_DATA-1:0]  r_ghash;
    logic                r_ghash_valid;
    logic [NB_COUNT-1:0] r_block_count;
    logic [NB_DATA-1:0]  r_mul_x;
    logic [NB_DATA-1:0]  r_mul_y;
    logic                r_mul_valid;
    logic                r_mul_trigger;

    logic                w_accept;
    logic [NB_DATA-1:0]  w_y_eff;

    // A clear arriving together with a block restarts the hash with that block.
    assign w_y_eff  = i_clear ? '0 : r_y;
    assign w_accept = i_block_valid & r_block_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_y           <= '0;
            r_last        <= 1'b0;
            r_block_ready <= 1'b0;
            r_ghash       <= '0;
            r_ghash_valid <= 1'b0;
            r_block_count <= '0;
            r_mul_x       <= '0;
            r_mul_y       <= '0;
            r_mul_valid   <= 1'b0;
            r_mul_trigger <= 1'b0;
        end else begin
            r_mul_valid   <= 1'b1;
            r_mul_trigger <= 1'b0;
            r_ghash_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mul_x       <= w_y_eff ^ i_block;
                        r_mul_y       <= i_hash_key;
                        r_last        <= i_block_last;
                        r_block_ready <= 1'b0;
                        // Trigger is registered here so it is high during TRIG.
                        r_mul_trigger <= 1'b1;
                        r_state       <= ST_TRIG;
                        if (i_clear) begin
                            r_y           <= '0;
                            r_block_count <= '0;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset.
                        r_block_ready <= 1'b1;
                        if (i_clear) begin
                            r_y           <= '0;
                            r_block_count <= '0;
                        end
                    end
                end
                ST_TRIG: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mul_done) begin
                        r_block_count <= r_block_count + NB_COUNT'(1);
                        r_block_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                        if (r_last) begin
                            r_ghash       <= i_mul_z;
                            r_ghash_valid <= 1'b1;
                            r_y           <= '0;
                        end else begin
                            r_y <= i_mul_z;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_block_ready = r_block_ready;
    assign o_ghash       = r_ghash;
    assign o_ghash_valid = r_ghash_valid;
    assign o_block_count = r_block_count;
    assign o_mul_x       = r_mul_x;
    assign o_mul_y       = r_mul_y;
    assign o_mul_valid   = r_mul_valid;
    assign o_mul_trigger = r_mul_trigger;

endmodule
